// File: rtl/scm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : scm_arb_pkg
// Brief  : Shared types and helpers for the SCM write-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package scm_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Counter must hold values 0..max_lock inclusive.
  function automatic int lock_cnt_width(input int max_lock);
    return $clog2(max_lock + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scm_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : scm_rr_pick
// Brief  : Combinational round-robin picker: one-hot grant of the first
//          requester at or after ptr, wrapping around.
// Rev    : 1.0 - initial release
// ============================================================================
module scm_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_gnt;
  logic [2*N-1:0] w_back;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_dbl     = {req, req} >> ptr;
    w_rot     = w_dbl[N-1:0];
    w_rot_gnt = w_rot & (~w_rot + N'(1));
    w_back    = {w_rot_gnt, w_rot_gnt} << ptr;
    gnt       = w_back[2*N-1:N];
  end

endmodule
`default_nettype wire

// File: rtl/scm_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module : scm_wport_arbiter
// Brief  : Round-robin write-port arbiter with lock support for a latch-based
//          register file; read ports pass through. Optional read-after-write
//          hazard stalling is enabled with macro SCM_WR_HAZARD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module scm_wport_arbiter
  import scm_arb_pkg::*;
#(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int MAX_LOCK   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_MASTER-1:0]                    wr_req_i,
  input  logic [N_MASTER-1:0]                    wr_lock_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]         wr_data_i,
  input  logic [N_MASTER*(DATA_WIDTH/8)-1:0]     wr_be_i,
  output logic [N_MASTER-1:0]                    wr_gnt_o,
  input  logic [N_READ-1:0]                      rd_req_i,
  input  logic [N_READ*ADDR_WIDTH-1:0]           rd_addr_i,
  output logic [N_READ-1:0]                      rd_gnt_o,
  output logic                                   WriteEnable,
  output logic [ADDR_WIDTH-1:0]                  WriteAddr,
  output logic [DATA_WIDTH-1:0]                  WriteData,
  output logic [DATA_WIDTH/8-1:0]                WriteBE,
  output logic [N_READ-1:0]                      ReadEnable,
  output logic [N_READ*ADDR_WIDTH-1:0]           ReadAddr,
  output logic [$clog2(N_MASTER)-1:0]            lock_owner_o,
  output logic                                   locked_o
);

  localparam int NUM_BYTE = DATA_WIDTH / 8;
  localparam int PTR_W    = $clog2(N_MASTER);
  localparam int CNT_W    = lock_cnt_width(MAX_LOCK);

  arb_state_e          r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_lock_cnt;

  logic [N_MASTER-1:0] w_pick;
  logic [N_MASTER-1:0] w_gnt;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_any_gnt;
  logic [CNT_W-1:0]    w_cnt_inc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_MASTER - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  scm_rr_pick #(.N(N_MASTER)) u_pick (
    .req (wr_req_i),
    .ptr (r_rr_ptr),
    .gnt (w_pick)
  );

  always_comb begin
    w_gnt = '0;
    if (rst_n) begin
      if (r_state == IDLE) begin
        w_gnt = w_pick;
      end else if (wr_req_i[r_owner]) begin
        w_gnt[r_owner] = 1'b1;
      end
    end
  end

  // One-hot grant lets the payload mux be a plain AND-OR, which is zero idle.
  always_comb begin
    w_gnt_idx = '0;
    WriteAddr = '0;
    WriteData = '0;
    WriteBE   = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      if (w_gnt[m]) begin
        w_gnt_idx = PTR_W'(m);
        WriteAddr = WriteAddr | wr_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        WriteData = WriteData | wr_data_i[m*DATA_WIDTH +: DATA_WIDTH];
        WriteBE   = WriteBE   | wr_be_i[m*NUM_BYTE +: NUM_BYTE];
      end
    end
  end

  assign w_any_gnt    = |w_gnt;
  assign w_cnt_inc    = r_lock_cnt + CNT_W'(1);
  assign wr_gnt_o     = w_gnt;
  assign WriteEnable  = w_any_gnt;
  assign lock_owner_o = r_owner;
  assign locked_o     = (r_state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_gnt) begin
            r_rr_ptr <= ptr_inc(w_gnt_idx);
            if (wr_lock_i[w_gnt_idx] && (MAX_LOCK > 1)) begin
              r_state    <= LOCKED;
              r_owner    <= w_gnt_idx;
              r_lock_cnt <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          // Release on idle owner, explicit unlock, or lock budget spent.
          if (!w_any_gnt || !wr_lock_i[r_owner] ||
              (w_cnt_inc == CNT_W'(MAX_LOCK))) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_rr_ptr   <= ptr_inc(r_owner);
          end else begin
            r_lock_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SCM_WR_HAZARD_EN
  logic                  r_prev_we;
  logic [ADDR_WIDTH-1:0] r_prev_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_we   <= 1'b0;
      r_prev_addr <= '0;
    end else begin
      r_prev_we   <= WriteEnable;
      r_prev_addr <= WriteAddr;
    end
  end

  // Stall reads that hit the word being written now or written last cycle.
  always_comb begin
    rd_gnt_o = '0;
    for (int p = 0; p < N_READ; p++) begin
      rd_gnt_o[p] = rst_n && rd_req_i[p] &&
        !(WriteEnable && (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == WriteAddr)) &&
        !(r_prev_we && (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == r_prev_addr));
    end
  end
`else
  assign rd_gnt_o = rd_req_i & {N_READ{rst_n}};
`endif

  assign ReadEnable = rd_req_i & rd_gnt_o;
  assign ReadAddr   = rd_addr_i;

endmodule
`default_nettype wire

// File: tb/tb_scm_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_scm_wport_arbiter
// Brief  : Table-driven self-checking bench for scm_wport_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_scm_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_req, wr_lock, wr_gnt;
  logic [19:0] wr_addr;
  logic [127:0] wr_data;
  logic [15:0] wr_be;
  logic [1:0]  rd_req, rd_gnt, rd_en;
  logic [9:0]  rd_addr, rd_addr_o;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [1:0]  owner;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scm_wport_arbiter #(
    .N_MASTER(4), .ADDR_WIDTH(5), .DATA_WIDTH(32), .N_READ(2), .MAX_LOCK(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req), .wr_lock_i(wr_lock),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .wr_gnt_o(wr_gnt),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .WriteEnable(we), .WriteAddr(waddr), .WriteData(wdata), .WriteBE(wbe),
    .ReadEnable(rd_en), .ReadAddr(rd_addr_o),
    .lock_owner_o(owner), .locked_o(locked)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       locked;
    logic [1:0] owner;
  } vec_t;

  vec_t        vecs[$];
  logic [4:0]  ma[4];
  logic [31:0] md[4];
  logic [3:0]  mb[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [3:0] g, input logic l, input logic [1:0] o);
    vec_t v;
    v.rst_n = r; v.req = rq; v.lock = lk; v.gnt = g; v.locked = l; v.owner = o;
    vecs.push_back(v);
  endtask

  task automatic load_payload();
    for (int m = 0; m < 4; m++) begin
      wr_addr[m*5 +: 5]   = ma[m];
      wr_data[m*32 +: 32] = md[m];
      wr_be[m*4 +: 4]     = mb[m];
    end
  endtask

  initial begin
    vec_t        v;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [1:0]  e_rd;

    for (int m = 0; m < 4; m++) begin
      ma[m] = 5'(10 + m);
      md[m] = 32'hA5000000 | 32'(m * 17 + 1);
      mb[m] = 4'(1 << m);
    end
    load_payload();
    rd_addr = {5'd31, 5'd30};
    rd_req  = 2'b00;
    wr_req  = 4'b0000;
    wr_lock = 4'b0000;
    rst_n   = 1'b0;

    //     rst   req      lock     gnt      lkd  own
    add_v(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b0, 2'd0);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b0100, 1'b0, 2'd0);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b0, 2'd0);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0);
    add_v(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add_v(1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b0, 2'd0);
    add_v(1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b0, 2'd0);
    // master 2 lock: 2,2,2 then 0 since 3 is idle
    add_v(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0);
    add_v(1'b1, 4'b0111, 4'b0100, 4'b0100, 1'b1, 2'd2);
    add_v(1'b1, 4'b0111, 4'b0000, 4'b0100, 1'b1, 2'd2);
    add_v(1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b0, 2'd0);
    // owner drops its request: others stall that cycle
    add_v(1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd0);
    add_v(1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd1);
    add_v(1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b0, 2'd0);
    // master 1 holds lock 10 cycles, MAX_LOCK = 8
    add_v(1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd0);
    for (int k = 0; k < 7; k++)
      add_v(1'b1, 4'b1010, 4'b0010, 4'b0010, 1'b1, 2'd1);
    add_v(1'b1, 4'b1010, 4'b0010, 4'b1000, 1'b0, 2'd0);
    add_v(1'b1, 4'b1010, 4'b0010, 4'b0010, 1'b0, 2'd0);
    // reset mid-lock
    add_v(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0);
    add_v(1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b0, 2'd0);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v       = vecs[i];
      rst_n   = v.rst_n;
      wr_req  = v.req;
      wr_lock = v.lock;
      rd_req  = 2'(i);
      @(negedge clk);
      e_addr = '0; e_data = '0; e_be = '0;
      for (int m = 0; m < 4; m++) begin
        if (v.gnt[m]) begin
          e_addr = ma[m]; e_data = md[m]; e_be = mb[m];
        end
      end
      e_rd = v.rst_n ? rd_req : 2'b00;
      check($sformatf("v%0d gnt", i),    64'(wr_gnt), 64'(v.gnt));
      check($sformatf("v%0d locked", i), 64'(locked), 64'(v.locked));
      check($sformatf("v%0d we", i),     64'(we),     64'(|v.gnt));
      check($sformatf("v%0d wpay", i),   {23'd0, e_addr, e_data, e_be}
                                        & 64'hFFFF_FFFF_FFFF_FFFF,
                                         {23'd0, waddr, wdata, wbe});
      check($sformatf("v%0d rd_gnt", i), 64'(rd_gnt), 64'(e_rd));
      check($sformatf("v%0d rd_en", i),  64'(rd_en),  64'(e_rd));
      check($sformatf("v%0d raddr", i),  64'(rd_addr_o), 64'(rd_addr));
      if (v.locked)
        check($sformatf("v%0d owner", i), 64'(owner), 64'(v.owner));
      @(posedge clk);
      #1;
    end

    // Write to word 5 from master 0 with reads of 5 and 6 in the same cycle.
    ma[0] = 5'd5; mb[0] = 4'b0011;
    load_payload();
    rd_addr = {5'd6, 5'd5};
    rd_req  = 2'b11;
    wr_lock = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      wr_req = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
`ifdef SCM_WR_HAZARD_EN
      e_rd = (c < 2) ? 2'b10 : 2'b11;
`else
      e_rd = 2'b11;
`endif
      check($sformatf("hz%0d we", c),    64'(we),    64'(c == 0));
      check($sformatf("hz%0d waddr", c), 64'(waddr), (c == 0) ? 64'd5 : 64'd0);
      check($sformatf("hz%0d wbe", c),   64'(wbe),   (c == 0) ? 64'd3 : 64'd0);
      check($sformatf("hz%0d rd_gnt", c), 64'(rd_gnt), 64'(e_rd));
      check($sformatf("hz%0d rd_en", c),  64'(rd_en),  64'(e_rd));
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scm_wport_arbiter.md
SCM_WPORT_ARBITER -- requirements
Module: scm_wport_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 4, meaning the number of write requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning the register-file word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning the word width; NUM_BYTE = DATA_WIDTH/8.
REQ-004 SHALL have parameter N_READ, default 2, meaning the number of read ports passed through.
REQ-005 SHALL have parameter MAX_LOCK, default 8, meaning the maximum number of consecutive grants in one lock.
REQ-006 SHALL have one clock; reset is synchronous and active-low. Ports: clk (in, 1, clock) and rst_n (in, 1, synchronous active-low reset).
REQ-007 SHALL have wr_req_i (in, N_MASTER, per-master write request).
REQ-008 SHALL have wr_lock_i (in, N_MASTER, requests that ownership be kept after this write).
REQ-009 SHALL have wr_addr_i, wr_data_i and wr_be_i (in, N_MASTER x ADDR_WIDTH / DATA_WIDTH / NUM_BYTE, per-master write payload).
REQ-010 SHALL have wr_gnt_o (out, N_MASTER, one-hot write grant, same cycle as the request).
REQ-011 SHALL have rd_req_i (in, N_READ, read request), rd_addr_i (in, N_READ x ADDR_WIDTH, read address) and rd_gnt_o (out, N_READ, read accepted).
REQ-012 SHALL have the register-file side ports WriteEnable, WriteAddr, WriteData, WriteBE, ReadEnable and ReadAddr (out, widths matching the register file).
REQ-013 SHALL have lock_owner_o (out, $clog2(N_MASTER), current owner) and locked_o (out, 1, lock active).

Function
REQ-014 SHALL assert at most one wr_gnt_o bit per cycle, and only when the matching wr_req_i bit is high.
REQ-015 SHALL, in state IDLE, grant the requesting master nearest at or after rr_ptr (wrapping from N_MASTER-1 to 0).
REQ-016 SHALL, after each grant in IDLE, set rr_ptr to (granted+1) mod N_MASTER; rr_ptr SHALL be unchanged when there is no grant.
REQ-017 SHALL drive WriteEnable equal to the OR of wr_gnt_o, with WriteAddr/WriteData/WriteBE muxed from the granted master, combinationally with zero added latency.
REQ-018 SHALL drive WriteAddr, WriteData and WriteBE to 0 when there is no grant.
REQ-019 SHALL, when a grant in IDLE has wr_lock_i high, transition to LOCKED with owner equal to the granted master and lock_cnt = 1.
REQ-020 SHALL, in LOCKED, grant only the owner; requests from other masters SHALL stall with wr_gnt_o low.
REQ-021 SHALL increment lock_cnt on each owner grant while in LOCKED.
REQ-022 SHALL leave LOCKED for IDLE when the owner is granted with wr_lock_i low, when the owner drops wr_req_i for a cycle, or when lock_cnt reaches MAX_LOCK with that grant.
REQ-023 SHALL, on leaving LOCKED, set rr_ptr to (owner+1) mod N_MASTER.
REQ-024 SHALL use a lock request from a master granted at lock_cnt = MAX_LOCK only as ordinary IDLE arbitration on later cycles.
REQ-025 SHALL drive ReadAddr = rd_addr_i and ReadEnable = rd_req_i & rd_gnt_o.
REQ-026 SHALL drive rd_gnt_o = rd_req_i when SCM_WR_HAZARD_EN is undefined.

Reset
REQ-027 SHALL, while rst_n is low at a clk edge, set state = IDLE, rr_ptr = 0, lock_cnt = 0 and owner = 0.
REQ-028 SHALL hold wr_gnt_o, WriteEnable and rd_gnt_o at 0 during any cycle in which rst_n is low, including reset asserted mid-lock.
REQ-029 SHALL give master 0 top priority on the first cycle after reset.

Configuration
REQ-030 SHALL, with SCM_WR_HAZARD_EN defined, hold rd_gnt_o[p] low and ReadEnable[p] low when rd_req_i[p] is high and rd_addr_i[p] equals WriteAddr while WriteEnable is high in the same cycle.
REQ-031 SHALL, with SCM_WR_HAZARD_EN defined, also stall rd_addr_i[p] while it equals the registered address of the previous cycle's write.
REQ-032 SHALL, with SCM_WR_HAZARD_EN undefined, contain no hazard comparators or registers.

Structure
REQ-033 SHALL place the state enum (IDLE, LOCKED) and the helper for the lock_cnt width in package scm_arb_pkg.
REQ-034 SHALL contain one sub-module, scm_rr_pick, which is combinational and takes a request vector and pointer and returns a one-hot grant.

Verification
REQ-035 SHALL cover reset then all four masters requesting continuously, without lock -> grants 0,1,2,3,0.
REQ-036 SHALL cover master 2 locking (wr_lock_i = 1) while masters 0 and 1 request -> grants 2,2,2 until the lock drops, then 3 if requesting, else 0.
REQ-037 SHALL cover master 1 holding the lock for 10 cycles with MAX_LOCK = 8 -> 8 grants to master 1, then a grant to another waiting master, with locked_o low for at least 1 cycle.
REQ-038 SHALL cover a write to address 5 with WriteBE = 0b0011, with a read of address 5 in the same cycle and SCM_WR_HAZARD_EN defined -> rd_gnt_o low for 2 cycles, then high; a read of address 6 in the same cycle is granted immediately.
REQ-039 SHALL cover rst_n asserted mid-lock -> the next cycle shows IDLE, locked_o = 0, and master 0 granted first.
REQ-040 SHALL cover the same stimulus as REQ-038 with SCM_WR_HAZARD_EN undefined -> rd_gnt_o = rd_req_i in every cycle.
